// File: rtl/act_pkg.sv
// rtl/act_pkg.sv - shared constants and types for the activation scheduler
// Purpose: activation control codes, Q6.10 constants and the scheduler state enum.
// Ports: none (package).
package act_pkg;

  localparam logic [3:0]  CTRL_IDLE    = 4'b0000;
  localparam logic [3:0]  CTRL_SIGMOID = 4'b0011;

  localparam int          FRAC_BITS    = 10;
  localparam logic [15:0] ONE_Q        = 16'h0400;
  localparam logic [15:0] HALF_Q       = 16'h0200;

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_t;

endpackage

// File: rtl/act_sched_if.sv
// rtl/act_sched_if.sv - requester, activation-unit and response bundle
// Purpose: groups every non-clock signal of act_sched.
// Ports (slave = scheduler side):
//   req_valid/req_ready/req_z/req_ctrl/req_last  per-requester element stream
//   act_ctrl/act_z/act_dout                      shared activation unit
//   rsp_valid/rsp_ready/rsp_data/rsp_id/rsp_last tagged response stream
//   busy                                         work pending anywhere
interface act_sched_if #(
  parameter int NUM_REQ = 2,
  parameter int DW      = 16,
  parameter int CW      = 4
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*DW-1:0] req_z;
  logic [NUM_REQ*CW-1:0] req_ctrl;
  logic [NUM_REQ-1:0]    req_last;

  logic [CW-1:0]         act_ctrl;
  logic [DW-1:0]         act_z;
  logic [DW-1:0]         act_dout;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DW-1:0]         rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_last;

  logic                  busy;

  modport slave (
    input  req_valid, req_z, req_ctrl, req_last, act_dout, rsp_ready,
    output req_ready, act_ctrl, act_z, rsp_valid, rsp_data, rsp_id, rsp_last, busy
  );

  modport master (
    output req_valid, req_z, req_ctrl, req_last, act_dout, rsp_ready,
    input  req_ready, act_ctrl, act_z, rsp_valid, rsp_data, rsp_id, rsp_last, busy
  );

endinterface

// File: rtl/act_rsp_fifo.sv
// rtl/act_rsp_fifo.sv - synchronous response FIFO with occupancy count
// Purpose: buffers tagged activation results until the consumer takes them.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   i_push/i_push_data  write side
//   i_pop/o_pop_data    read side (head is visible combinationally)
//   o_count       number of stored entries
module act_rsp_fifo #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_pop_data,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH + 1);

  logic [W-1:0]    r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CNTW-1:0] r_count;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= ptr_inc(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNTW'(1);
        2'b01:   r_count <= r_count - CNTW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // Upstream credit accounting must make these impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(i_push && !i_pop && (r_count == CNTW'(DEPTH))));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(i_pop && (r_count == '0)));

endmodule

// File: rtl/act_sched.sv
// rtl/act_sched.sv - round-robin burst scheduler for a shared activation unit
// Purpose: grants one requester per burst, streams its elements into the
//   activation unit, tracks results in flight and returns them tagged with the
//   requester id through a credit-protected response FIFO.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  act_sched_if.slave (requests, activation unit, responses, busy)
module act_sched
  import act_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DW        = 16,
  parameter int CW        = 4,
  parameter int ACT_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  act_sched_if.slave bus
);

  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int FW   = DW + IDW + 1;
  localparam int CNTW = $clog2(RSP_DEPTH + 1);
  localparam int UW   = $clog2(RSP_DEPTH + ACT_LAT + 2);

  state_t             r_state;
  logic [IDW-1:0]     r_owner;
  logic [IDW-1:0]     r_rr_ptr;
  logic [CW-1:0]      r_act_ctrl;
  logic [DW-1:0]      r_act_z;
  // In-flight pipe: stage 0 lines up with the act_* register, the last stage
  // lines up with the activation unit's output.
  logic [ACT_LAT:0]   r_pv;
  logic [ACT_LAT:0]   r_plast;
  logic [IDW-1:0]     r_pid [ACT_LAT+1];

  logic [CNTW-1:0]    w_fifo_count;
  logic [UW-1:0]      w_inflight;
  logic [UW-1:0]      w_used;
  logic               w_credit_ok;
  logic               w_accept;
  logic               w_owner_last;
  logic               w_found;
  logic [IDW-1:0]     w_win;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [FW-1:0]      w_head;
  logic               w_pop;

  always_comb begin
    w_inflight = '0;
    for (int k = 0; k <= ACT_LAT; k++) begin
      w_inflight = w_inflight + UW'(r_pv[k]);
    end
  end

  // A slot is reserved from issue until the consumer pops the result, so the
  // FIFO can never be asked to take more than it holds.
  assign w_used      = UW'(w_fifo_count) + w_inflight;
  assign w_credit_ok = (w_used < UW'(RSP_DEPTH));

  always_comb begin
    w_req_ready = '0;
    if (r_state == S_BURST && w_credit_ok) begin
      w_req_ready[r_owner] = 1'b1;
    end
  end

  assign w_accept     = (r_state == S_BURST) && bus.req_valid[r_owner] && w_credit_ok;
  assign w_owner_last = bus.req_last[r_owner];

  // Round-robin search starting at r_rr_ptr, wrapping around.
  always_comb begin
    w_win   = r_rr_ptr;
    w_found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_win   = IDW'((int'(r_rr_ptr) + k) % NUM_REQ);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= '0;
      r_rr_ptr   <= '0;
      r_act_ctrl <= CW'(CTRL_IDLE);
      r_act_z    <= '0;
      r_pv       <= '0;
      r_plast    <= '0;
      for (int k = 0; k <= ACT_LAT; k++) begin
        r_pid[k] <= '0;
      end
    end else begin
      r_act_ctrl <= CW'(CTRL_IDLE);
      r_pv[0]    <= w_accept;
      r_plast[0] <= w_owner_last;
      r_pid[0]   <= r_owner;
      for (int k = 1; k <= ACT_LAT; k++) begin
        r_pv[k]    <= r_pv[k-1];
        r_plast[k] <= r_plast[k-1];
        r_pid[k]   <= r_pid[k-1];
      end

      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner <= w_win;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          // The grant stays locked until the owner's last element goes in,
          // even across gaps in its req_valid.
          if (w_accept) begin
            r_act_z    <= bus.req_z[int'(r_owner)*DW +: DW];
            r_act_ctrl <= bus.req_ctrl[int'(r_owner)*CW +: CW];
            if (w_owner_last) begin
              r_state  <= S_IDLE;
              r_rr_ptr <= IDW'((int'(r_owner) + 1) % NUM_REQ);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_pop = (w_fifo_count != '0) && bus.rsp_ready;

  act_rsp_fifo #(
    .W     (FW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (r_pv[ACT_LAT]),
    .i_push_data ({bus.act_dout, r_pid[ACT_LAT], r_plast[ACT_LAT]}),
    .i_pop       (w_pop),
    .o_pop_data  (w_head),
    .o_count     (w_fifo_count)
  );

  assign bus.req_ready = w_req_ready;
  assign bus.act_ctrl  = r_act_ctrl;
  assign bus.act_z     = r_act_z;
  assign bus.rsp_valid = (w_fifo_count != '0);
  assign bus.rsp_data  = w_head[FW-1 -: DW];
  assign bus.rsp_id    = w_head[IDW:1];
  assign bus.rsp_last  = w_head[0];
  assign bus.busy      = (r_state == S_BURST) || (w_used != '0);

endmodule

// File: tb/tb_act_sched.sv
// tb/tb_act_sched.sv - directed self-checking bench for act_sched
module tb_act_sched;
  import act_pkg::*;

  localparam int NUM_REQ   = 2;
  localparam int DW        = 16;
  localparam int CW        = 4;
  localparam int ACT_LAT   = 1;
  localparam int RSP_DEPTH = 4;

  typedef struct packed {
    logic [15:0] d;
    logic        id;
    logic        last;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  act_sched_if #(.NUM_REQ(NUM_REQ), .DW(DW), .CW(CW)) bus ();

  act_sched #(
    .NUM_REQ   (NUM_REQ),
    .DW        (DW),
    .CW        (CW),
    .ACT_LAT   (ACT_LAT),
    .RSP_DEPTH (RSP_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Hard sigmoid 0.5 + z/8 clamped to [0,1] in Q6.10.
  function automatic logic [15:0] hsig(input logic [15:0] z);
    int v;
    v = int'(HALF_Q) + (int'($signed(z)) >>> 3);
    if (v < 0) v = 0;
    if (v > int'(ONE_Q)) v = int'(ONE_Q);
    return v[15:0];
  endfunction

  // Activation unit: registered, updates only on sigmoid, holds otherwise.
  logic [15:0] act_q = '0;
  always @(posedge clk) begin
    if (bus.act_ctrl == CTRL_SIGMOID) act_q <= hsig(bus.act_z);
  end
  assign bus.act_dout = act_q;

  int   n_chk  = 0;
  int   n_pass = 0;
  rsp_t got_q[$];
  rsp_t exp_q[$];
  int   acc_q[$];
  int   st_n[2];
  int   st_e[2];
  int   st_blen = 1;

  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready)
      got_q.push_back({bus.rsp_data, bus.rsp_id, bus.rsp_last});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    got_q.delete();
    exp_q.delete();
    acc_q.delete();
  endtask

  function automatic logic [15:0] zval(input int r, input int e);
    return 16'(r * 32'h0800 + e * 32'h0100);
  endfunction

  task automatic start(input int n0, input int n1, input int blen);
    st_n[0] = n0;
    st_n[1] = n1;
    st_e[0] = 0;
    st_e[1] = 0;
    st_blen = blen;
  endtask

  task automatic drive_streams();
    for (int i = 0; i < 2; i++) begin
      bus.req_valid[i]          = (st_e[i] < st_n[i]);
      bus.req_z[i*16 +: 16]     = zval(i, st_e[i]);
      bus.req_ctrl[i*4 +: 4]    = CTRL_SIGMOID;
      bus.req_last[i]           = ((st_e[i] % st_blen) == st_blen - 1);
    end
  endtask

  task automatic run(input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      if (st_e[0] >= st_n[0] && st_e[1] >= st_n[1]) break;
      drive_streams();
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          acc_q.push_back(i);
          exp_q.push_back({hsig(zval(i, st_e[i])), 1'(i), bus.req_last[i]});
          st_e[i]++;
        end
      end
      @(posedge clk);
      #1;
    end
    drive_streams();
  endtask

  task automatic send(input int i, input logic [15:0] z, input logic [3:0] c, input logic l);
    logic ok;
    ok = 1'b0;
    bus.req_valid[i]       = 1'b1;
    bus.req_z[i*16 +: 16]  = z;
    bus.req_ctrl[i*4 +: 4] = c;
    bus.req_last[i]        = l;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      ok = bus.req_ready[i];
      @(posedge clk);
      #1;
    end
    chk("send_accepted", 32'(ok), 32'd1);
  endtask

  task automatic idle(input int i);
    bus.req_valid[i] = 1'b0;
    bus.req_last[i]  = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int c = 0; c < 100 && got_q.size() < n; c++) tick(1);
    chk("rsp_count", 32'(got_q.size()), 32'(n));
  endtask

  task automatic check_vs_exp(input string tag);
    chk({tag, "_n"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
      chk(tag, 32'(got_q[k]), 32'(exp_q[k]));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start(0, 0, 1);
    drive_streams();
    tick(2);
    rst = 1'b0;
    clr();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_z     = '0;
    bus.req_ctrl  = '0;
    bus.req_last  = '0;
    bus.rsp_ready = 1'b0;
    start(0, 0, 1);

    // Reset state
    rst = 1'b1;
    tick(2);
    chk("rst_act_ctrl",  32'(bus.act_ctrl),  32'h0);
    chk("rst_act_z",     32'(bus.act_z),     32'h0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    rst = 1'b0;
    tick(1);

    // Single burst with latency
    bus.rsp_ready = 1'b1;
    clr();
    send(0, 16'h0000, 4'b0011, 1'b0);
    chk("t1_lat0",     32'(bus.rsp_valid), 32'd0);
    chk("t1_act_ctrl", 32'(bus.act_ctrl),  32'h3);
    chk("t1_act_z",    32'(bus.act_z),     32'h0);
    send(0, 16'h1800, 4'b0011, 1'b0);
    chk("t1_lat1",     32'(bus.rsp_valid), 32'd0);
    send(0, 16'hE800, 4'b0011, 1'b1);
    chk("t1_lat2",     32'(bus.rsp_valid), 32'd1);
    chk("t1_first",    32'(bus.rsp_data),  32'h0200);
    idle(0);
    wait_rsp(3);
    chk("t1_rsp0", 32'(got_q[0]), 32'({16'h0200, 1'b0, 1'b0}));
    chk("t1_rsp1", 32'(got_q[1]), 32'({16'h0400, 1'b0, 1'b0}));
    chk("t1_rsp2", 32'(got_q[2]), 32'({16'h0000, 1'b0, 1'b1}));
    tick(2);
    chk("t1_busy_done", 32'(bus.busy), 32'd0);

    // Contention then strict alternation
    do_reset();
    start(6, 6, 2);
    run(80);
    chk("t2_done0", 32'(st_e[0]), 32'd6);
    chk("t2_done1", 32'(st_e[1]), 32'd6);
    wait_rsp(12);
    for (int k = 0; k < 12; k++)
      chk("t2_order", 32'(acc_q[k]), 32'((k / 2) % 2));
    check_vs_exp("t2_rsp");

    // Backpressure
    clr();
    bus.rsp_ready = 1'b0;
    start(8, 0, 8);
    run(12);
    chk("t3_accepted", 32'(acc_q.size()),  32'(RSP_DEPTH));
    chk("t3_ready",    32'(bus.req_ready), 32'h0);
    chk("t3_rsp_valid",32'(bus.rsp_valid), 32'd1);
    chk("t3_no_pop",   32'(got_q.size()),  32'd0);
    chk("t3_busy",     32'(bus.busy),      32'd1);
    bus.rsp_ready = 1'b1;
    run(60);
    chk("t3_done", 32'(st_e[0]), 32'd8);
    wait_rsp(8);
    check_vs_exp("t3_rsp");
    tick(3);
    chk("t3_busy_done", 32'(bus.busy), 32'd0);

    // Non-sigmoid code returns the held value
    clr();
    send(0, 16'h0400, 4'b0011, 1'b0);
    send(0, 16'h0000, 4'b0001, 1'b1);
    chk("t4_passthru", 32'(bus.act_ctrl), 32'h1);
    idle(0);
    wait_rsp(2);
    chk("t4_rsp0", 32'(got_q[0]), 32'({16'h0280, 1'b0, 1'b0}));
    chk("t4_rsp1", 32'(got_q[1]), 32'({16'h0280, 1'b0, 1'b1}));
    tick(2);

    // Reset mid-burst: 2 in flight, 2 in the FIFO
    clr();
    bus.rsp_ready = 1'b0;
    start(8, 0, 8);
    run(5);
    chk("t5_pre_acc",   32'(acc_q.size()),  32'd4);
    chk("t5_pre_valid", 32'(bus.rsp_valid), 32'd1);
    chk("t5_pre_busy",  32'(bus.busy),      32'd1);
    rst = 1'b1;
    start(0, 0, 1);
    drive_streams();
    tick(1);
    chk("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("t5_busy",      32'(bus.busy),      32'd0);
    chk("t5_act_ctrl",  32'(bus.act_ctrl),  32'h0);
    chk("t5_req_ready", 32'(bus.req_ready), 32'h0);
    rst = 1'b0;
    clr();
    bus.rsp_ready = 1'b1;
    start(0, 3, 3);
    run(20);
    wait_rsp(3);
    check_vs_exp("t5_rsp");
    tick(3);
    chk("t5_busy_done", 32'(bus.busy), 32'd0);

    // Owner bubble while the other requester waits
    clr();
    send(0, 16'h0000, 4'b0011, 1'b0);
    send(0, 16'h0800, 4'b0011, 1'b0);
    idle(0);
    bus.req_valid[1]      = 1'b1;
    bus.req_z[16 +: 16]   = 16'h0400;
    bus.req_ctrl[4 +: 4]  = CTRL_SIGMOID;
    bus.req_last[1]       = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk("t6_no_switch", 32'(bus.req_ready), 32'h1);
    end
    chk("t6_bubble_ctrl", 32'(bus.act_ctrl), 32'h0);
    send(0, 16'hF800, 4'b0011, 1'b1);
    idle(0);
    send(1, 16'h0400, 4'b0011, 1'b1);
    idle(1);
    wait_rsp(4);
    chk("t6_rsp0", 32'(got_q[0]), 32'({16'h0200, 1'b0, 1'b0}));
    chk("t6_rsp1", 32'(got_q[1]), 32'({16'h0300, 1'b0, 1'b0}));
    chk("t6_rsp2", 32'(got_q[2]), 32'({16'h0100, 1'b0, 1'b1}));
    chk("t6_rsp3", 32'(got_q[3]), 32'({16'h0280, 1'b1, 1'b1}));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/act_sched.md
Name: act_sched

Overview:
- Sequencer/arbiter that shares one activation unit among NUM_REQ requesters, e.g. the DQN policy and target networks.
- The activation unit is registered, Q6.10 signed, and 1-cycle latency. It updates only when ctrl = 4'b0011 (sigmoid) and holds its output otherwise.
- act_sched grants one requester for a whole vector burst and streams that burst's pre-activations into the unit. It captures results after ACT_LAT cycles and returns them through a response FIFO, tagged with the requester ID.

Parameters:
- NUM_REQ, 2, number of requesters.
- DW, 16, data width (Q6.10 signed).
- CW, 4, activation control code width.
- ACT_LAT, 1, activation unit latency in cycles.
- RSP_DEPTH, 4, response FIFO depth; must be >= ACT_LAT+1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester element valid.
- req_ready  out  NUM_REQ  per-requester element accepted.
- req_z  in  NUM_REQ*DW  packed pre-activations; requester i occupies bits [i*DW +: DW].
- req_ctrl  in  NUM_REQ*CW  packed activation codes.
- req_last  in  NUM_REQ  last element of the burst.
- act_ctrl  out  CW  to activation unit.
- act_z  out  DW  to activation unit.
- act_dout  in  DW  from activation unit.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_data  out  DW  activated value.
- rsp_id  out  clog2(NUM_REQ)  originating requester.
- rsp_last  out  1  last response of the burst.
- busy  out  1  burst active or results in flight or FIFO non-empty.

Behaviour:
- Reset values: act_ctrl = CTRL_IDLE (4'b0000), act_z = 0, req_ready = 0, rsp_valid = 0, busy = 0. rr_ptr = 0, owner = 0, credit logic cleared, FIFO empty, in-flight pipe cleared.
- State machine, two states:
  - IDLE: if any req_valid, register the round-robin winner as owner, searching from rr_ptr upward with wrap. Go to BURST next cycle (one bubble cycle per burst).
  - BURST: stay until the owner's element with req_last = 1 is accepted. Then set rr_ptr = owner+1 mod NUM_REQ and return to IDLE.
- Issue rule:
  - In BURST, req_ready[owner] = (free > 0); all other req_ready bits are 0.
  - free = RSP_DEPTH - fifo_count - inflight.
  - Accept happens when req_valid[owner] && req_ready[owner].
  - On accept: register act_z = req_z[owner] and act_ctrl = req_ctrl[owner]. Otherwise act_ctrl = CTRL_IDLE.
  - Accept rate: 1 element per cycle.
- In-flight tracking:
  - A shift pipe of length ACT_LAT+1 carries {valid, id, last}. Its entry stage is the act_* register; the activation unit adds ACT_LAT.
  - When a valid entry exits the pipe, push {act_dout, id, last} into the FIFO.
  - The credit check guarantees the FIFO never overflows; overflow is an assertion failure.
- Response side:
  - FIFO head drives rsp_*; pop on rsp_valid && rsp_ready.
  - Simultaneous push and pop keeps the count unchanged.
  - A full FIFO with rsp_ready = 0 forces req_ready = 0, with no data loss.
- Ctrl passthrough: codes are not interpreted. A non-sigmoid code still occupies a slot and returns the unit's held value. CTRL_IDLE is never issued on behalf of a requester.
- Owner deasserting req_valid mid-burst: the burst stays locked with no grant change; bubbles are allowed.
- Reset mid-burst: everything returns to reset values the next cycle. In-flight and FIFO contents are discarded.
- Latency: accept at cycle t gives rsp_valid at t+ACT_LAT+1, provided the FIFO was empty.

Decomposition:
- Package act_pkg holds: CTRL_IDLE = 4'b0000, CTRL_SIGMOID = 4'b0011, Q-format constants (FRAC_BITS = 10, ONE_Q = 16'h0400, HALF_Q = 16'h0200), and the state enum {S_IDLE, S_BURST}.
- One sub-module, act_rsp_fifo: sync FIFO, width DW+IDW+1, depth RSP_DEPTH, exposing a count output.

Test Plan:
- Single burst: req 0 sends 3 elements z = 0, 16'h1800, 16'hE800 with ctrl 0011, last on the 3rd. Expect rsp_data 16'h0200, 16'h0400, 16'h0000, rsp_id = 0, rsp_last on the 3rd, first response 2 cycles after accept.
- Contention: both requesters valid with 2-element bursts. Expect the req 0 burst fully, then req 1. Requesters continuously valid afterward alternate strictly 0,1,0,1.
- Backpressure: rsp_ready = 0 and req 0 streams 8 elements. Expect exactly RSP_DEPTH results buffered, req_ready low, no loss. Raising rsp_ready drains all 8 in order.
- Non-sigmoid code: z = 16'h0400 with ctrl 0011, then z = 0 with ctrl 0001. Expect the second response equal to the held value of the first (16'h0280).
- Reset mid-burst: assert rst with 2 in flight and 2 in the FIFO. Next cycle expect rsp_valid = 0, busy = 0, act_ctrl = 0; a new burst from req 1 is served normally.
- Bubble in burst: owner drops req_valid for 3 cycles mid-burst while the other requester is valid. Expect no grant switch and correct rsp_last.
